ifetch_icache: RTL and testbench
================================

Name: ifetch_icache

Overview:
- Instruction fetch stage. Sits directly upstream of the instruction queue.
- Holds the architectural fetch PC and looks it up in a small direct-mapped, one-word-per-line instruction cache.
- On a hit, pushes {inst, pc} into the queue. On a miss, requests the word from the memory controller, fills the cache, then retries.
- The ROB flush redirects the fetch PC. There is no branch prediction; the next PC is always pc+4.

Parameters:
- ICACHE_IDX_W, 6: index width; the cache has 2^ICACHE_IDX_W lines. Index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
- RESET_PC, 32'h0: fetch PC after reset.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state is frozen
- rob_flush_in  input  1  pipeline flush / redirect
- rob_target_pc_in  input  32  redirect PC; valid when rob_flush_in=1
- iqueue_rdy_in  input  1  queue can accept one more entry this cycle
- iqueue_en_out  output  1  one-cycle push strobe to the queue
- iqueue_inst_out  output  32  instruction pushed
- iqueue_pc_out  output  32  PC of the instruction pushed
- memctrl_req_out  output  1  fetch request, level; held until done
- memctrl_addr_out  output  32  word address requested
- memctrl_done_in  input  1  one-cycle strobe; memctrl_inst_in is valid
- memctrl_inst_in  input  32  fetched word

Behaviour:
- Reset (rst_in=1 at posedge):
  - pc=RESET_PC; state=IDLE; all valid bits cleared; flush_pending=0.
  - iqueue_en_out=0, iqueue_inst_out=0, iqueue_pc_out=0.
  - memctrl_req_out=0, memctrl_addr_out=0.
  - Reset mid-miss abandons the request. A later memctrl_done_in is ignored in IDLE.
- Default per cycle: iqueue_en_out<=0 and iqueue_inst_out/iqueue_pc_out<=0, unless a push occurs. Pushes are single-cycle pulses.
- rdy_in=0: pc, state, cache, memctrl_req_out and memctrl_addr_out hold. iqueue_en_out<=0. No push, no fill.
- State IDLE (rdy_in=1):
  - rob_flush_in=1: pc<=rob_target_pc_in; no push; no request; stay IDLE. Flush has priority over hit and miss.
  - Otherwise, if iqueue_rdy_in=0: stall, nothing changes.
  - Otherwise, hit (valid[idx] and tag match):
    - iqueue_en_out<=1, iqueue_inst_out<=data[idx], iqueue_pc_out<=pc.
    - pc<=pc+4, modulo 2^32.
    - Sustained throughput is one instruction per cycle.
  - Otherwise, miss:
    - memctrl_req_out<=1; memctrl_addr_out<=pc; miss_addr<=pc.
    - flush_pending<=0; state<=WAIT.
- State WAIT (rdy_in=1):
  - memctrl_req_out and memctrl_addr_out stay constant until done.
  - rob_flush_in=1: pc<=rob_target_pc_in; flush_pending<=1. The request is not aborted.
  - memctrl_done_in=1:
    - Write data[idx(miss_addr)]<=memctrl_inst_in, set tag and valid.
    - memctrl_req_out<=0; state<=IDLE. No push this cycle.
    - The next IDLE cycle re-looks-up pc. That is the original address (hit) or the flush target.
  - Flush and done in the same cycle: fill with miss_addr, pc<=rob_target_pc_in, go to IDLE.
  - flush_pending is informational only; the fill is always legal because the data matches miss_addr.
- Miss penalty: request issued 1 cycle after the lookup; push occurs 1 cycle after the done cycle, given iqueue_rdy_in=1.
- At most one outstanding memory request. memctrl_done_in outside WAIT is ignored.
- The cache is never invalidated except by reset. Self-modifying code is unsupported.
- Cache index/tag extraction uses only the PC; PCs are word aligned, and pc[1:0] is ignored.

Test Plan:
1. Reset, RESET_PC=0; memctrl returns word 0x11 at addr 0 after 3 cycles, iqueue_rdy_in=1.
   - Required: req asserted with addr 0 one cycle after reset release; held 3 cycles.
   - Required: push {inst 0x11, pc 0} one cycle after done; next request is addr 4.
2. Loop: flush to 0x0 after 0x0–0x0C are cached.
   - Required: pushes pc 0,4,8,0xC on 4 consecutive cycles with no memctrl_req_out.
3. Hold iqueue_rdy_in=0 for 5 cycles during the hit run.
   - Required: no pushes and pc unchanged.
   - Required: resumes at the same PC when ready returns; no instruction duplicated or skipped.
4. Flush to 0x100 while in WAIT for addr 0x20.
   - Required: req stays high until done; line 0x20 filled; no push of 0x20.
   - Required: next request is addr 0x100; a later fetch of 0x20 hits.
5. rob_flush_in and a hit in the same IDLE cycle.
   - Required: iqueue_en_out=0 that cycle; next lookup uses the target PC.
6. rdy_in=0 for 3 cycles mid-WAIT with done pulsed while rdy_in=0 (memctrl also frozen, so the pulse is re-presented later).
   - Required: state, req and pc unchanged; iqueue_en_out=0 throughout.
   - Required: reset asserted in WAIT returns all outputs to 0 the next cycle.

Source files
------------

// File: rtl/ifetch_icache.sv
// ifetch_icache: holds the fetch PC and looks it up in a direct-mapped, one-word-per-line I-cache.
// Latency: a hit pushes {inst, pc} one cycle after lookup (1/cycle); a miss pushes one cycle after memctrl done.
// Backpressure: iqueue_rdy_in=0 stalls the lookup, rdy_in=0 freezes everything, one outstanding request.
module ifetch_icache #(
   parameter int          ICACHE_IDX_W = 6,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_flush_in,
   input  logic [31:0] rob_target_pc_in,
   input  logic        iqueue_rdy_in,
   output logic        iqueue_en_out,
   output logic [31:0] iqueue_inst_out,
   output logic [31:0] iqueue_pc_out,
   output logic        memctrl_req_out,
   output logic [31:0] memctrl_addr_out,
   input  logic        memctrl_done_in,
   input  logic [31:0] memctrl_inst_in
);

   localparam int NLINES = 1 << ICACHE_IDX_W;
   localparam int TAG_W  = 30 - ICACHE_IDX_W;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                  r_state, w_state_nxt;
   logic [31:0]             r_pc, w_pc_nxt;
   logic [31:2]             r_miss_addr, w_miss_addr_nxt;
   logic                    r_flush_pending, w_flush_pending_nxt;
   logic [NLINES-1:0]       r_valid;
   logic [TAG_W-1:0]        r_tag  [NLINES];
   logic [31:0]             r_data [NLINES];
   logic                    r_iq_en, w_iq_en_nxt;
   logic [31:0]             r_iq_inst, w_iq_inst_nxt;
   logic [31:0]             r_iq_pc, w_iq_pc_nxt;
   logic                    r_req, w_req_nxt;
   logic [31:0]             r_addr, w_addr_nxt;

   logic [ICACHE_IDX_W-1:0] w_idx, w_fill_idx;
   logic [TAG_W-1:0]        w_tag, w_fill_tag;
   logic                    w_hit;
   logic                    w_fill;
   logic                    w_unused;

   assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
   assign w_tag      = r_pc[31:ICACHE_IDX_W+2];
   assign w_fill_idx = r_miss_addr[ICACHE_IDX_W+1:2];
   assign w_fill_tag = r_miss_addr[31:ICACHE_IDX_W+2];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   // flush_pending is a debug-visible record of a redirect during a miss; no datapath consumes it,
   // because the fill always writes data that belongs to miss_addr.
   assign w_unused = r_flush_pending;

   assign iqueue_en_out    = r_iq_en;
   assign iqueue_inst_out  = r_iq_inst;
   assign iqueue_pc_out    = r_iq_pc;
   assign memctrl_req_out  = r_req;
   assign memctrl_addr_out = r_addr;

   // Next-state and output decode: flush beats hit/miss in IDLE; WAIT holds the request until done.
   always_comb begin
      w_state_nxt         = r_state;
      w_pc_nxt            = r_pc;
      w_miss_addr_nxt     = r_miss_addr;
      w_flush_pending_nxt = r_flush_pending;
      w_iq_en_nxt         = 1'b0;
      w_iq_inst_nxt       = 32'h0;
      w_iq_pc_nxt         = 32'h0;
      w_req_nxt           = r_req;
      w_addr_nxt          = r_addr;
      w_fill              = 1'b0;
      if (rdy_in) begin
         case (r_state)
            ST_IDLE: begin
               if (rob_flush_in) begin
                  w_pc_nxt = rob_target_pc_in;
               end else if (iqueue_rdy_in) begin
                  if (w_hit) begin
                     w_iq_en_nxt   = 1'b1;
                     w_iq_inst_nxt = r_data[w_idx];
                     w_iq_pc_nxt   = r_pc;
                     w_pc_nxt      = r_pc + 32'd4;
                  end else begin
                     w_req_nxt           = 1'b1;
                     w_addr_nxt          = r_pc;
                     w_miss_addr_nxt     = r_pc[31:2];
                     w_flush_pending_nxt = 1'b0;
                     w_state_nxt         = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // A redirect only moves the PC; the outstanding fill still completes into its own line.
               if (rob_flush_in) begin
                  w_pc_nxt            = rob_target_pc_in;
                  w_flush_pending_nxt = 1'b1;
               end
               if (memctrl_done_in) begin
                  w_fill      = 1'b1;
                  w_req_nxt   = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Control state, valid bits and registered outputs, with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state         <= ST_IDLE;
         r_pc            <= RESET_PC;
         r_miss_addr     <= '0;
         r_flush_pending <= 1'b0;
         r_valid         <= '0;
         r_iq_en         <= 1'b0;
         r_iq_inst       <= 32'h0;
         r_iq_pc         <= 32'h0;
         r_req           <= 1'b0;
         r_addr          <= 32'h0;
      end else begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_miss_addr     <= w_miss_addr_nxt;
         r_flush_pending <= w_flush_pending_nxt;
         r_iq_en         <= w_iq_en_nxt;
         r_iq_inst       <= w_iq_inst_nxt;
         r_iq_pc         <= w_iq_pc_nxt;
         r_req           <= w_req_nxt;
         r_addr          <= w_addr_nxt;
         if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays need no reset; valid bits gate every read.
   always_ff @(posedge clk_in) begin
      if (w_fill && !rst_in) begin
         r_data[w_fill_idx] <= memctrl_inst_in;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end
   end

endmodule

// File: tb/tb_ifetch_icache.sv
// tb_ifetch_icache: directed scenarios plus randomized traffic against a PC/cache-content reference model.
// Latency: model predicts the push/request seen after each clock edge from the inputs applied at that edge.
// Backpressure: randomizes rdy_in, iqueue_rdy_in, flushes, resets and memory latency (memctrl frozen by rdy_in).
module tb_ifetch_icache;

   localparam int          IDX_W = 6;
   localparam int          NL    = 1 << IDX_W;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_flush_in;
   logic [31:0] rob_target_pc_in;
   logic        iqueue_rdy_in;
   logic        iqueue_en_out;
   logic [31:0] iqueue_inst_out;
   logic [31:0] iqueue_pc_out;
   logic        memctrl_req_out;
   logic [31:0] memctrl_addr_out;
   logic        memctrl_done_in;
   logic [31:0] memctrl_inst_in;

   ifetch_icache #(.ICACHE_IDX_W(IDX_W), .RESET_PC(RST_PC)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .rob_flush_in     (rob_flush_in),
      .rob_target_pc_in (rob_target_pc_in),
      .iqueue_rdy_in    (iqueue_rdy_in),
      .iqueue_en_out    (iqueue_en_out),
      .iqueue_inst_out  (iqueue_inst_out),
      .iqueue_pc_out    (iqueue_pc_out),
      .memctrl_req_out  (memctrl_req_out),
      .memctrl_addr_out (memctrl_addr_out),
      .memctrl_done_in  (memctrl_done_in),
      .memctrl_inst_in  (memctrl_inst_in)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: fetch PC, outstanding miss, and which word address each line currently holds
   logic [31:0] m_pc;
   logic        m_wait;
   logic [31:0] m_addr;
   logic        m_vld   [NL];
   logic [31:0] m_laddr [NL];

   // memory controller responder
   logic        mc_busy, mc_done, mc_spur;
   int          mc_cnt, mc_lat;
   logic [31:0] mc_addr;

   // observations of the DUT used by directed timing checks
   logic d_prev_req;
   int   n_req, n_push, n_done, d_req_run, d_req_len, d_done_cyc, d_push_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h11;
      return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'(a[IDX_W+1:2]);
   endfunction

   function automatic logic m_hit(input logic [31:0] a);
      return m_vld[m_idx(a)] && (m_laddr[m_idx(a)][31:2] == a[31:2]);
   endfunction

   task automatic drive_mc();
      memctrl_done_in = mc_done;
      memctrl_inst_in = (mc_done && !mc_spur) ? mem_word(mc_addr) : $urandom;
   endtask

   // one clock: predict, compare, observe, then let the memory controller react
   task automatic tick();
      logic        a_rst, a_rdy, a_fl, a_iq, a_dn, e_en;
      logic [31:0] a_tgt, e_pc;
      a_rst = rst_in; a_rdy = rdy_in; a_fl = rob_flush_in;
      a_iq  = iqueue_rdy_in; a_dn = memctrl_done_in; a_tgt = rob_target_pc_in;
      @(posedge clk_in); #1;
      cyc++;
      e_en = 1'b0; e_pc = 32'h0;
      if (a_rst) begin
         m_pc = RST_PC; m_wait = 1'b0; m_addr = 32'h0;
         for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
      end else if (a_rdy) begin
         if (m_wait) begin
            if (a_fl) m_pc = a_tgt;
            if (a_dn) begin
               m_vld[m_idx(m_addr)]   = 1'b1;
               m_laddr[m_idx(m_addr)] = m_addr;
               m_wait = 1'b0;
            end
         end else if (a_fl) begin
            m_pc = a_tgt;
         end else if (a_iq) begin
            if (m_hit(m_pc)) begin
               e_en = 1'b1; e_pc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
               m_wait = 1'b1; m_addr = m_pc;
            end
         end
      end
      chk("push_en",   32'(iqueue_en_out), 32'(e_en));
      chk("push_pc",   iqueue_pc_out, e_pc);
      chk("push_inst", iqueue_inst_out, e_en ? mem_word(e_pc) : 32'h0);
      chk("mem_req",   32'(memctrl_req_out), 32'(m_wait));
      chk("mem_addr",  memctrl_addr_out, m_addr);

      if (!a_rst && a_rdy && a_dn && d_prev_req) begin d_done_cyc = cyc; n_done++; end
      if (memctrl_req_out && !d_prev_req) begin n_req++; d_req_run = 0; end
      if (memctrl_req_out) d_req_run++;
      if (!memctrl_req_out && d_prev_req) d_req_len = d_req_run;
      d_prev_req = memctrl_req_out;
      if (iqueue_en_out) begin n_push++; d_push_cyc = cyc; end

      if (a_rst) begin
         mc_busy = 1'b0; mc_done = 1'b0; mc_spur = 1'b0;
      end else if (mc_done) begin
         if (a_rdy) begin mc_done = 1'b0; mc_busy = 1'b0; mc_spur = 1'b0; end
      end else if (mc_busy) begin
         if (a_rdy) begin mc_cnt--; if (mc_cnt == 0) mc_done = 1'b1; end
      end else if (memctrl_req_out) begin
         mc_busy = 1'b1; mc_addr = memctrl_addr_out; mc_cnt = mc_lat - 1;
         if (mc_cnt == 0) mc_done = 1'b1;
      end
      drive_mc();
   endtask

   task automatic wait_push(input string tag, input int budget);
      int n0 = n_push;
      for (int k = 0; k < budget && n_push == n0; k++) tick();
      chk(tag, 32'(n_push - n0), 32'd1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n0 = n_req;
      for (int k = 0; k < budget && n_req == n0; k++) tick();
      chk(tag, 32'(n_req - n0), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n0 = n_done;
      for (int k = 0; k < budget && n_done == n0; k++) tick();
      chk(tag, 32'(n_done - n0), 32'd1);
   endtask

   task automatic wait_push_pc(input string tag, input logic [31:0] pc, input int budget);
      logic seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         seen = iqueue_en_out && (iqueue_pc_out == pc);
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic flush_to(input logic [31:0] tgt);
      rob_flush_in = 1'b1; rob_target_pc_in = tgt;
      tick();
      rob_flush_in = 1'b0;
   endtask

   function automatic logic [31:0] rnd_target();
      logic [31:0] r = $urandom;
      case ($urandom % 8)
         0:       return 32'hFFFF_FFF0 | (r & 32'hC);
         1:       return 32'h8000_0000 | (r & 32'h3FC);
         default: return r & 32'h3FC;
      endcase
   endfunction

   initial begin
      int r0, nr0;
      rst_in = 1'b1; rdy_in = 1'b1; rob_flush_in = 1'b0; rob_target_pc_in = 32'h0;
      iqueue_rdy_in = 1'b1; memctrl_done_in = 1'b0; memctrl_inst_in = 32'h0;
      mc_busy = 1'b0; mc_done = 1'b0; mc_spur = 1'b0; mc_cnt = 0; mc_lat = 3; mc_addr = 32'h0;
      d_prev_req = 1'b0; n_req = 0; n_push = 0; n_done = 0;
      d_req_run = 0; d_req_len = 0; d_done_cyc = 0; d_push_cyc = 0;
      m_pc = RST_PC; m_wait = 1'b0; m_addr = 32'h0;
      for (int i = 0; i < NL; i++) begin m_vld[i] = 1'b0; m_laddr[i] = 32'h0; end

      tick(); tick();

      // cold start: request for 0 right after reset, 3-cycle memory, push one cycle after done
      rst_in = 1'b0;
      r0 = cyc;
      tick();
      chk("t1_req_cycle", 32'(n_req), 32'd1);
      chk("t1_req_addr", memctrl_addr_out, 32'h0);
      wait_push("t1_first_push", 20);
      chk("t1_req_len", 32'(d_req_len), 32'd3);
      chk("t1_push_lat", 32'(d_push_cyc - d_done_cyc), 32'd1);
      chk("t1_push_pc", iqueue_pc_out, 32'h0);
      chk("t1_push_inst", iqueue_inst_out, 32'h11);
      wait_req("t1_next_req", 10);
      chk("t1_next_addr", memctrl_addr_out, 32'h4);
      wait_push_pc("t1_reach_c", 32'hC, 60);

      // cached loop runs back to back with no memory traffic
      flush_to(32'h0);
      nr0 = n_req;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_loop_en", 32'(iqueue_en_out), 32'd1);
         chk("t2_loop_pc", iqueue_pc_out, 32'(i * 4));
      end
      chk("t2_no_req", 32'(n_req - nr0), 32'd0);

      // flush wins over a hit in the same cycle
      flush_to(32'h0);
      tick();
      flush_to(32'h8);
      chk("t5_flush_en", 32'(iqueue_en_out), 32'd0);
      tick();
      chk("t5_target_pc", iqueue_pc_out, 32'h8);

      // queue backpressure during a hit run
      iqueue_rdy_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_stall_en", 32'(iqueue_en_out), 32'd0);
      end
      iqueue_rdy_in = 1'b1;
      tick();
      chk("t3_resume_pc", iqueue_pc_out, 32'hC);

      // redirect while waiting on 0x20: fill completes, no push of 0x20, then fetch 0x100
      flush_to(32'h20);
      tick();
      chk("t4_req_addr", memctrl_addr_out, 32'h20);
      flush_to(32'h100);
      wait_done("t4_done", 10);
      chk("t4_req_len", 32'(d_req_len), 32'd3);
      wait_req("t4_next_req", 10);
      chk("t4_next_addr", memctrl_addr_out, 32'h100);
      wait_push_pc("t4_push_100", 32'h100, 20);
      nr0 = n_req;
      flush_to(32'h20);
      tick();
      chk("t4_hit_20", iqueue_pc_out, 32'h20);
      chk("t4_hit_noreq", 32'(n_req - nr0), 32'd0);

      // global stall across the done pulse, then reset from WAIT
      flush_to(32'h200);
      for (int k = 0; k < 10 && !mc_done; k++) tick();
      chk("t6_done_ready", 32'(mc_done), 32'd1);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_frozen_req", 32'(memctrl_req_out), 32'd1);
         chk("t6_frozen_addr", memctrl_addr_out, 32'h200);
      end
      rdy_in = 1'b1;
      tick();
      tick();
      chk("t6_push_200", iqueue_pc_out, 32'h200);
      wait_req("t6_req_204", 10);
      rst_in = 1'b1;
      tick();
      chk("t6_rst_req", 32'(memctrl_req_out), 32'd0);
      rst_in = 1'b0;
      iqueue_rdy_in = 1'b0;
      mc_done = 1'b1; mc_spur = 1'b1;
      drive_mc();
      tick();
      iqueue_rdy_in = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rdy_in           = ($urandom % 8) != 0;
         iqueue_rdy_in    = ($urandom % 4) != 0;
         rob_flush_in     = ($urandom % 16) == 0;
         rob_target_pc_in = rnd_target();
         rst_in           = ($urandom % 600) == 0;
         mc_lat           = int'($urandom_range(1, 5));
         if (!mc_busy && !mc_done && !memctrl_req_out && ($urandom % 10) == 0) begin
            mc_done = 1'b1; mc_spur = 1'b1;
            drive_mc();
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
